// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch-address sequencer (seq/beq/jalr/trap/eret, stall, halt); optional PC_PERF_CNT_EN perf counters
module pc_sequencer #(
  parameter int              PC_W      = 16,
  parameter int              IMM_W     = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('h0010),
  parameter int              CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       op_i,
  input  logic [PC_W-1:0]  alu_out_i,
  input  logic [PC_W-1:0]  reg_b_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic             ex_valid_i,
  input  logic             stall_i,
  input  logic             trap_req_i,
  input  logic             eret_i,
  input  logic             halt_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic [PC_W-1:0]  epc_o,
  output logic             redirect_o,
  output logic [1:0]       state_o
`ifdef PC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
`endif
);
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, HALT = 2'b10, TRAP = 2'b11} state_e;
  state_e          state_q;
  logic [PC_W-1:0] pc_q, epc_q, pc_d, seq_pc, beq_pc, imm_sext;
  logic            pc_valid_q, redirect_q;
  logic            is_jalr, beq_taken, trap_entry, run_acc, taken;
  assign imm_sext   = {{(PC_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign seq_pc     = pc_q + PC_W'(1);
  assign beq_pc     = seq_pc + imm_sext;
  assign is_jalr    = op_i == 3'b111;
  assign beq_taken  = op_i == 3'b110 && alu_out_i == reg_b_i;
  assign trap_entry = trap_req_i && (state_q == RUN || state_q == HALT);
  assign run_acc    = state_q == RUN && ex_valid_i && !stall_i && !trap_req_i;
  assign taken      = run_acc && (eret_i || (!halt_i && (is_jalr || beq_taken)));
  // target of an accepted RUN update, in eret > jalr > beq > sequential order
  always_comb begin
    pc_d = eret_i ? epc_q : is_jalr ? alu_out_i : beq_taken ? beq_pc : seq_pc;
  end
  // FSM with registered pc/epc/pc_valid/redirect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      pc_valid_q <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      if (trap_entry) begin
        state_q    <= TRAP;
        epc_q      <= pc_q;
        pc_q       <= TRAP_VEC;
        pc_valid_q <= 1'b0;
        redirect_q <= 1'b1;
      end else begin
        case (state_q)
          BOOT, TRAP: begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end
          RUN: if (run_acc) begin
            if (halt_i && !eret_i) begin
              state_q    <= HALT;
              pc_valid_q <= 1'b0;
            end else begin
              pc_q       <= pc_d;
              redirect_q <= taken;
            end
          end
          HALT: pc_valid_q <= 1'b0;
        endcase
      end
    end
  end
  assign pc_o       = pc_q;
  assign pc_valid_o = pc_valid_q;
  assign epc_o      = epc_q;
  assign redirect_o = redirect_q;
  assign state_o    = state_q;
`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, taken_cnt_q;
  // retired and taken-redirect counts, both wrapping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      if (run_acc) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      if (taken) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end
  assign retire_cnt_o = retire_cnt_q;
  assign taken_cnt_o  = taken_cnt_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table-driven bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [2:0]  op;
  logic [15:0] alu_out, reg_b, pc, epc;
  logic [7:0]  imm;
  logic        ex_valid, stall, trap_req, eret, halt, pc_valid, redirect;
  logic [1:0]  state;
  int          checks = 0, errors = 0;
`ifdef PC_PERF_CNT_EN
  logic [31:0] retire_cnt, taken_cnt;
`endif
  pc_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .alu_out_i(alu_out), .reg_b_i(reg_b), .imm_i(imm),
    .ex_valid_i(ex_valid), .stall_i(stall), .trap_req_i(trap_req), .eret_i(eret), .halt_i(halt),
    .pc_o(pc), .pc_valid_o(pc_valid), .epc_o(epc), .redirect_o(redirect), .state_o(state)
`ifdef PC_PERF_CNT_EN
    , .retire_cnt_o(retire_cnt), .taken_cnt_o(taken_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] op; logic [15:0] alu, rb; logic [7:0] imm;
    logic exv, stl, trp, ert, hlt;
    logic [15:0] pc, epc; logic pv, red; logic [1:0] st;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(logic [2:0] o, logic [15:0] a, logic [15:0] b, logic [7:0] i,
                              logic e, logic s, logic t, logic r, logic h,
                              logic [15:0] p, logic [15:0] ep, logic v, logic d, logic [1:0] st);
    vec_t x;
    x.op = o; x.alu = a; x.rb = b; x.imm = i; x.exv = e; x.stl = s; x.trp = t; x.ert = r; x.hlt = h;
    x.pc = p; x.epc = ep; x.pv = v; x.red = d; x.st = st;
    return x;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic chk_all(string tag, logic [15:0] p, logic [15:0] ep, logic v, logic d, logic [1:0] st);
    chk({tag, " pc"}, 32'(pc), 32'(p));
    chk({tag, " epc"}, 32'(epc), 32'(ep));
    chk({tag, " pc_valid"}, 32'(pc_valid), 32'(v));
    chk({tag, " redirect"}, 32'(redirect), 32'(d));
    chk({tag, " state"}, 32'(state), 32'(st));
  endtask
  task automatic step(string tag, vec_t x);
    @(negedge clk);
    op = x.op; alu_out = x.alu; reg_b = x.rb; imm = x.imm;
    ex_valid = x.exv; stall = x.stl; trap_req = x.trp; eret = x.ert; halt = x.hlt;
    @(posedge clk);
    #1;
    chk_all(tag, x.pc, x.epc, x.pv, x.red, x.st);
  endtask
  initial begin
    op = 3'd0; alu_out = '0; reg_b = '0; imm = '0;
    ex_valid = 0; stall = 0; trap_req = 0; eret = 0; halt = 0;
    #1 rst_n = 1'b0;
    #1 chk_all("reset", 16'h0000, 16'h0000, 0, 0, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    #1 chk_all("boot", 16'h0000, 16'h0000, 0, 0, 2'b00);
    @(posedge clk); #1 chk_all("run0", 16'h0000, 16'h0000, 1, 0, 2'b01);
    for (int i = 1; i <= 5; i++) step($sformatf("seq%0d", i), mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 16'(i), 0, 1, 0, 1));
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk_all("midreset", 16'h0000, 16'h0000, 0, 0, 2'b00);
`ifdef PC_PERF_CNT_EN
    chk("midreset retire", retire_cnt, 0);
    chk("midreset taken", taken_cnt, 0);
`endif
    ex_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    #1 chk_all("reboot", 16'h0000, 16'h0000, 0, 0, 2'b00);
    @(posedge clk); #1 chk_all("rerun", 16'h0000, 16'h0000, 1, 0, 2'b01);
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h0001, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0001, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 'h0001, 0, 1, 0, 1));
    tv.push_back(mk(7, 'h0010, 0, 0, 1, 0, 0, 0, 0, 'h0010, 0, 1, 1, 1));
    tv.push_back(mk(6, 'h1234, 'h1234, 'hFE, 1, 0, 0, 0, 0, 'h000F, 0, 1, 1, 1));
    tv.push_back(mk(7, 'h0010, 0, 0, 1, 0, 0, 0, 0, 'h0010, 0, 1, 1, 1));
    tv.push_back(mk(6, 'h1235, 'h1234, 'hFE, 1, 0, 0, 0, 0, 'h0011, 0, 1, 0, 1));
    tv.push_back(mk(7, 'h0010, 0, 0, 1, 0, 0, 0, 0, 'h0010, 0, 1, 1, 1));
    for (int i = 0; i < 3; i++) tv.push_back(mk(7, 'h0100, 0, 0, 1, 1, 0, 0, 0, 'h0010, 0, 1, 0, 1));
    tv.push_back(mk(7, 'h0100, 0, 0, 1, 0, 0, 0, 0, 'h0100, 0, 1, 1, 1));
    tv.push_back(mk(7, 'hFFFF, 0, 0, 1, 0, 0, 0, 0, 'hFFFF, 0, 1, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h0000, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h0001, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h0002, 0, 1, 0, 1));
    tv.push_back(mk(6, 5, 5, 'h80, 1, 0, 0, 0, 0, 'hFF83, 0, 1, 1, 1));
    tv.push_back(mk(6, 5, 5, 'h7F, 1, 0, 0, 0, 0, 'h0003, 0, 1, 1, 1));
    tv.push_back(mk(7, 'h0042, 0, 0, 1, 0, 0, 0, 0, 'h0042, 0, 1, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 'h0010, 'h0042, 0, 1, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h0010, 'h0042, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h0011, 'h0042, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h0011, 'h0042, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 'h0042, 'h0042, 1, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 'h0042, 'h0042, 1, 1, 1));
    tv.push_back(mk(7, 'h0020, 0, 0, 1, 0, 0, 0, 0, 'h0020, 'h0042, 1, 1, 1));
    tv.push_back(mk(7, 'h0099, 0, 0, 1, 0, 0, 0, 1, 'h0020, 'h0042, 0, 0, 2));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h0020, 'h0042, 0, 0, 2));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 'h0020, 'h0042, 0, 0, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0020, 'h0042, 0, 0, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h0010, 'h0020, 0, 1, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0010, 'h0020, 1, 0, 1));
    tv.push_back(mk(7, 'h0055, 0, 0, 1, 0, 1, 0, 0, 'h0010, 'h0010, 0, 1, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0010, 'h0010, 1, 0, 1));
    foreach (tv[i]) step($sformatf("row%0d", i), tv[i]);
`ifdef PC_PERF_CNT_EN
    chk("retire_cnt", retire_cnt, 19);
    chk("taken_cnt", taken_cnt, 12);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
